// File: rtl/gain_pkg.sv
// rtl/gain_pkg.sv - shared types, constants and level helper for gain_sched
package gain_pkg;

    localparam int DEF_DATA_W = 16;

    typedef logic [1:0] level_t;

    localparam level_t LEVEL_MAX = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_L,
        ISSUE_R,
        CAP_R,
        DONE
    } state_t;

    function automatic level_t level_next(input level_t level);
        return (level == LEVEL_MAX) ? 2'd0 : level + 2'd1;
    endfunction

endpackage

// File: rtl/gain_sched_button_debounce.sv
// rtl/gain_sched_button_debounce.sv - button synchronizer, optional debounce, rising-edge press pulse
// GAIN_SCHED_DEBOUNCE_EN enables the DEB_CYCLES stability counter.
module button_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_button,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_deb_prev;
    logic r_press;
    logic w_deb;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GAIN_SCHED_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_state;

    // Count only while the input disagrees with the accepted state; agreement restarts the count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (r_sync2 == r_state) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_deb = r_state;
`else
    assign w_deb = r_sync2;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_deb_prev <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_deb_prev <= w_deb;
            r_press    <= w_deb & ~r_deb_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/gain_sched.sv
// rtl/gain_sched.sv - time-shares one gain datapath between L/R samples, frame-aligned volume level
// Debounce of the pedal button is compiled in with GAIN_SCHED_DEBOUNCE_EN.
module gain_sched
    import gain_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEB_CYCLES = 50000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Button,
    input  logic              frame_valid,
    input  logic [DATA_W-1:0] L_in,
    input  logic [DATA_W-1:0] R_in,
    output logic [DATA_W-1:0] dp_in,
    output level_t            dp_level,
    input  logic [DATA_W-1:0] dp_out,
    output logic [DATA_W-1:0] L_out,
    output logic [DATA_W-1:0] R_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output level_t            volume_level
);

    state_t            r_state;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_hold_l;
    logic              w_press;
    logic              w_accept;

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_button_debounce (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_button (Button),
        .o_press  (w_press)
    );

    assign w_accept = frame_valid && ((r_state == IDLE) || (r_state == DONE));

    // dp_in is loaded with L at the latch edge so it is stable for the whole ISSUE_L cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_r          <= '0;
            r_hold_l     <= '0;
            dp_in        <= '0;
            dp_level     <= '0;
            L_out        <= '0;
            R_out        <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            volume_level <= '0;
        end else begin
            out_valid <= 1'b0;
            if (w_press) begin
                volume_level <= level_next(volume_level);
            end
            if (frame_valid && !w_accept) begin
                overrun <= 1'b1;
            end
            if (w_accept) begin
                dp_in    <= L_in;
                r_r      <= R_in;
                dp_level <= volume_level;
            end
            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        r_state <= ISSUE_L;
                        busy    <= 1'b1;
                    end
                end
                ISSUE_L: begin
                    dp_in   <= r_r;
                    r_state <= ISSUE_R;
                end
                ISSUE_R: begin
                    r_hold_l <= dp_out;
                    r_state  <= CAP_R;
                end
                CAP_R: begin
                    L_out     <= r_hold_l;
                    R_out     <= dp_out;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (frame_valid) begin
                        r_state <= ISSUE_L;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gain_sched.md
# gain_sched

Controller that time-shares one external gain datapath between the left and right channels of each stereo audio frame. It also turns the pedal button into a 2-bit volume level and applies that level only on frame boundaries, so a level change never lands mid-frame. It sits between the codec sample interface and the shared gain unit, and owns all sequencing and level state for it.

## Interface
- DATA_W, 16: audio sample width, two's complement.
- DEB_CYCLES, 50000: number of consecutive stable cycles the button must hold before its debounced value changes. Used only when debounce is compiled in.
- Clk  in  1  system clock.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
- Button  in  1  raw pedal button, asynchronous, 1 = pressed.
- frame_valid  in  1  single-cycle pulse; L_in and R_in are valid in the same cycle.
- L_in, R_in  in  DATA_W each  input samples.
- dp_in  out  DATA_W  sample driven to the shared gain datapath.
- dp_level  out  2  level applied to the current frame.
- dp_out  in  DATA_W  datapath result, exactly one cycle after dp_in.
- L_out, R_out  out  DATA_W each  processed samples.
- out_valid  out  1  single-cycle pulse; L_out and R_out are updated together in this cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky flag: a frame was dropped.
- volume_level  out  2  requested level, intended for LEDs.

## Operation
- FSM states: IDLE, ISSUE_L, ISSUE_R, CAP_R, DONE.
  - IDLE: on frame_valid, latch L_in, R_in and volume_level into dp_level, then go to ISSUE_L.
  - ISSUE_L: dp_in = latched L. Go to ISSUE_R.
  - ISSUE_R: dp_in = latched R; capture dp_out into the L hold register. Go to CAP_R.
  - CAP_R: capture dp_out into the R hold register. Go to DONE.
  - DONE: L_out and R_out load from the hold registers; out_valid = 1.
    - With frame_valid this cycle: latch the new frame and go to ISSUE_L.
    - Otherwise: go to IDLE.
- Frames are accepted only in IDLE and DONE.
- frame_valid in ISSUE_L, ISSUE_R or CAP_R:
  - the frame is dropped and overrun is set;
  - the in-flight frame completes unaffected.
- overrun clears only on Reset.
- dp_in holds its last value outside the ISSUE states.
- dp_level changes only when a frame is latched.
- Button path:
  - 2-flop synchronizer, then the debouncer, then rising-edge detect.
  - Each rising edge increments volume_level, wrapping 3 -> 0.
  - A press while busy updates volume_level immediately; it reaches dp_level at the next frame latch.
- Widths: no arithmetic on samples inside this block; all samples are passed through at DATA_W bits.

## Timing
- Reset values:
  - FSM in IDLE;
  - dp_in, L_out, R_out = 0;
  - dp_level, volume_level = 0;
  - out_valid, busy, overrun = 0;
  - debouncer counter and state = 0 (not pressed).
- Latency: frame_valid sampled at cycle t gives out_valid at t+4.
- Maximum throughput: one frame every 4 cycles, using back-to-back acceptance in DONE.
- Reset asserted mid-frame: the frame is abandoned, with no out_valid pulse, and all outputs take their reset values on the next edge.
- Button edge coinciding with a frame latch: the frame uses the pre-increment level; volume_level shows the new value one cycle later.
- Button path latency: 2 cycles of synchronizer, plus DEB_CYCLES when debounce is enabled, plus 1 cycle of edge detect.

## Configuration
- GAIN_SCHED_DEBOUNCE_EN defined: the debounced value changes only after the synchronized button has been stable for DEB_CYCLES consecutive cycles. Any change of input during the count restarts it.
- Not defined: the synchronizer output drives the edge detector directly. DEB_CYCLES is ignored and no counter is instantiated.

## Structure
- Shared package gain_pkg holds:
  - the FSM state enum;
  - the default DATA_W;
  - typedef level_t (logic [1:0]);
  - constant LEVEL_MAX = 3.
- One sub-module, button_debounce:
  - contains the synchronizer, the optional debounce counter and the rising-edge detect;
  - outputs a single-cycle press pulse.

## Test plan
- Reset, then a single frame L=0x1000, R=0xF000 at level 0 with a pass-through datapath model: out_valid exactly 4 cycles later; L_out=0x1000, R_out=0xF000; busy high for 4 cycles.
- Three button presses, then a frame: dp_level=3 for that frame. A fourth press makes volume_level=0 and the next frame uses 0.
- frame_valid pulses at t and t+4: both complete, out_valid at t+4 and t+8, overrun stays 0. A pulse at t+2: that frame is dropped and overrun=1 until Reset.
- Press during ISSUE_R: the current frame keeps the old dp_level; the next frame uses the new one.
- Reset at t+2 of a frame: no out_valid, all outputs 0, and a subsequent frame processes normally.
- With GAIN_SCHED_DEBOUNCE_EN and DEB_CYCLES=8:
  - a 5-cycle button glitch gives no level change;
  - a 12-cycle press gives exactly one increment.
